// File: rtl/mul_pkg.sv
// Shared types for the multiplier dispatch stage: widths, FSM states and the
// operand-pair record carried through the issue FIFO.
package mul_pkg;

  localparam int OP_W   = 16;
  localparam int PROD_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_HI,
    ST_WAIT_LO,
    ST_HOLD
  } mul_disp_state_t;

  typedef struct packed {
    logic [OP_W-1:0] x;
    logic [OP_W-1:0] y;
  } mul_ops_t;

endpackage

// File: rtl/mul_op_fifo.sv
// Synchronous FIFO of operand pairs; the head entry is read combinationally
// from the read pointer so the issue stage can latch it without extra delay.
module mul_op_fifo
  import mul_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  mul_ops_t               push_data,
  input  logic                   pop,
  output mul_ops_t               head,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

  mul_ops_t      mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == FULL_LEVEL);
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers are exactly AW bits wide, so they wrap on their own at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      level <= level + 1'b1;
      else if (do_pop && !do_push) level <= level - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mul_dispatch.sv
// Operand issue / product capture stage in front of the Booth multiplier.
// Define MUL_DISPATCH_TIMEOUT_EN to add a watchdog on both busy-wait states.
module mul_dispatch
  import mul_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [OP_W-1:0]        in_x,
  input  logic [OP_W-1:0]        in_y,
  output logic [OP_W-1:0]        mul_x,
  output logic [OP_W-1:0]        mul_y,
  output logic                   mul_start,
  input  logic                   mul_busy,
  input  logic [PROD_W-1:0]      mul_z,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [PROD_W-1:0]      res_z,
  output logic                   res_err,
  output logic [$clog2(DEPTH):0] level
);

  mul_disp_state_t state;
  mul_disp_state_t state_next;

  mul_ops_t push_data;
  mul_ops_t head;
  logic     fifo_full;
  logic     fifo_empty;
  logic     push;
  logic     pop;
  logic     capture;
  logic     abort;
  logic     wait_expired;
  logic     res_accept;

  assign push_data  = '{x: in_x, y: in_y};
  assign in_ready   = !fifo_full;
  assign push       = in_valid && in_ready;
  assign pop        = (state == ST_ISSUE);
  assign res_accept = (state == ST_HOLD) && res_ready;

  mul_op_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .head     (head),
    .level    (level),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    abort      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!fifo_empty) state_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        state_next = ST_WAIT_HI;
      end
      ST_WAIT_HI: begin
        if (mul_busy) begin
          state_next = ST_WAIT_LO;
        end else if (wait_expired) begin
          abort      = 1'b1;
          state_next = ST_HOLD;
        end
      end
      ST_WAIT_LO: begin
        if (!mul_busy) begin
          capture    = 1'b1;
          state_next = ST_HOLD;
        end else if (wait_expired) begin
          abort      = 1'b1;
          state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (res_ready) state_next = fifo_empty ? ST_IDLE : ST_ISSUE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Operands are latched on entry to ISSUE so they are stable for the whole
  // multiplication; mul_start is therefore high exactly while in ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_start <= 1'b0;
      mul_x     <= '0;
      mul_y     <= '0;
      res_valid <= 1'b0;
      res_z     <= '0;
    end else begin
      mul_start <= (state_next == ST_ISSUE);
      if (state_next == ST_ISSUE) begin
        mul_x <= head.x;
        mul_y <= head.y;
      end
      if (capture) begin
        res_z     <= mul_z;
        res_valid <= 1'b1;
      end else if (abort) begin
        res_z     <= '0;
        res_valid <= 1'b1;
      end else if (res_accept) begin
        res_valid <= 1'b0;
      end
    end
  end

`ifdef MUL_DISPATCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT) + 1;

  logic [TW-1:0] wait_cnt;

  assign wait_expired = (wait_cnt == TW'(TIMEOUT - 1));

  // Restarts on every state change, so each wait state gets its own budget.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (state_next != state) begin
      wait_cnt <= '0;
    end else if (state == ST_WAIT_HI || state == ST_WAIT_LO) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       res_err <= 1'b0;
    else if (capture) res_err <= 1'b0;
    else if (abort)   res_err <= 1'b1;
  end
`else
  assign wait_expired = 1'b0;
  assign res_err      = 1'b0;
`endif

endmodule

// File: tb/tb_mul_dispatch.sv
// Scoreboard bench for mul_dispatch with a behavioural 16-cycle multiplier model.
// Build with MUL_DISPATCH_TIMEOUT_EN to also exercise the watchdog abort path.
module tb_mul_dispatch;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;
  localparam int AW      = $clog2(DEPTH);

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_x, in_y;
  logic [15:0] mul_x, mul_y;
  logic        mul_start;
  logic        mul_busy;
  logic [31:0] mul_z;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_z;
  logic        res_err;
  logic [AW:0] level;

  int          checks = 0;
  int          errors = 0;
  logic [32:0] exp_q[$];
  logic [31:0] op_q[$];
  int          ready_mode = 1;
  logic        mul_stall = 1'b0;
  logic        prev_start = 1'b0;
  logic        hs_seen = 1'b0;
  int          hs_level = 0;
  logic [15:0] model_x, model_y;

  mul_dispatch #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_x     (in_x),
    .in_y     (in_y),
    .mul_x    (mul_x),
    .mul_y    (mul_y),
    .mul_start(mul_start),
    .mul_busy (mul_busy),
    .mul_z    (mul_z),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_z    (res_z),
    .res_err  (res_err),
    .level    (level)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Two's-complement product from plain integer arithmetic.
  function automatic logic [31:0] refProduct(input logic [15:0] a, input logic [15:0] b);
    int sa, sb;
    sa = (a >= 16'h8000) ? int'(a) - 65536 : int'(a);
    sb = (b >= 16'h8000) ? int'(b) - 65536 : int'(b);
    return 32'(sa * sb);
  endfunction

  task automatic checkReset(input string tag);
    checkOutput({tag, "_in_ready"},  32'(in_ready),  32'd1);
    checkOutput({tag, "_mul_start"}, 32'(mul_start), 32'd0);
    checkOutput({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    checkOutput({tag, "_res_err"},   32'(res_err),   32'd0);
    checkOutput({tag, "_res_z"},     res_z,          32'd0);
    checkOutput({tag, "_mul_xy"},    {mul_x, mul_y}, 32'd0);
    checkOutput({tag, "_level"},     32'(level),     32'd0);
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic applyStimulus(input logic [15:0] x, input logic [15:0] y,
                               input logic [31:0] z, input logic e);
    int n = 0;
    in_x = x;
    in_y = y;
    in_valid = 1'b1;
    while (!in_ready && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      in_valid = 1'b0;
      checkOutput("push_accept_timeout", 32'(in_ready), 32'd1);
    end else begin
      exp_q.push_back({e, z});
      op_q.push_back({x, y});
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput(name, 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  // Multiplier model: busy one cycle after start, 16 cycles busy, then product.
  initial begin
    mul_busy = 1'b0;
    mul_z    = '0;
    forever begin
      @(negedge clk);
      if (mul_start && !mul_stall) begin
        model_x = mul_x;
        model_y = mul_y;
        @(posedge clk); #1;
        mul_busy = 1'b1;
        repeat (16) @(posedge clk);
        #1;
        mul_z    = $signed({{16{model_x[15]}}, model_x}) * $signed({{16{model_y[15]}}, model_y});
        mul_busy = 1'b0;
      end
    end
  end

  initial begin
    res_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       res_ready = 1'b0;
        1:       res_ready = 1'b1;
        default: res_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: issue operands, results in order, and back-to-back issue timing.
  initial begin
    logic [32:0] exp;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_start = 1'b0;
        hs_seen    = 1'b0;
      end else begin
        if (hs_seen)
          checkOutput("issue_after_handshake", 32'(mul_start), (hs_level > 0) ? 32'd1 : 32'd0);
        hs_seen = 1'b0;
        if (mul_start) begin
          checkOutput("start_not_consecutive", 32'(prev_start), 32'd0);
          if (op_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL spurious_issue: got x=0x%04h y=0x%04h, expected no issue", mul_x, mul_y);
          end else begin
            checkOutput("issue_operands", {mul_x, mul_y}, op_q.pop_front());
          end
        end
        if (res_valid && res_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL spurious_result: got z=0x%08h err=%0d, expected none", res_z, res_err);
          end else begin
            exp = exp_q.pop_front();
            checkOutput("result_z",   res_z,          exp[31:0]);
            checkOutput("result_err", 32'(res_err),   32'(exp[32]));
          end
          hs_seen  = 1'b1;
          hs_level = int'(level);
        end
        prev_start = mul_start;
      end
    end
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] rx, ry;
    int n;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_x     = '0;
    in_y     = '0;
    #12;
    checkReset("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    ready_mode = 1;
    @(posedge clk); #1;

    // Single op: start pulse is the cycle after the accepting edge.
    applyStimulus(16'd3, 16'd5, 32'h0000000F, 1'b0);
    checkOutput("single_level_after_push", 32'(level), 32'd1);
    checkOutput("single_no_early_start", 32'(mul_start), 32'd0);
    @(posedge clk); #1;
    checkOutput("single_start_e1", 32'(mul_start), 32'd1);
    waitDrain("single_drain");
    checkOutput("single_level_empty", 32'(level), 32'd0);
    checkOutput("single_in_ready", 32'(in_ready), 32'd1);

    applyStimulus(16'hFFFE, 16'd7, 32'hFFFFFFF2, 1'b0);
    applyStimulus(16'h8000, 16'h8000, 32'h40000000, 1'b0);
    waitDrain("signed_drain");

    // Fill with results blocked: FIFO saturates and the 6th push stalls.
    ready_mode = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      rx = 16'($urandom);
      ry = 16'($urandom);
      applyStimulus(rx, ry, refProduct(rx, ry), 1'b0);
    end
    checkOutput("fill_level_full", 32'(level), 32'd4);
    checkOutput("fill_in_ready_low", 32'(in_ready), 32'd0);
    fork
      applyStimulus(16'h1234, 16'hFEDC, refProduct(16'h1234, 16'hFEDC), 1'b0);
      begin
        repeat (6) @(posedge clk);
        #1;
        checkOutput("fill_sixth_waits", 32'(in_ready), 32'd0);
        ready_mode = 1;
      end
    join
    waitDrain("fill_drain");

    // Back-to-back: four queued ops drained with the consumer always ready.
    for (int i = 0; i < 4; i++) begin
      rx = 16'($urandom);
      ry = 16'($urandom);
      applyStimulus(rx, ry, refProduct(rx, ry), 1'b0);
    end
    waitDrain("b2b_drain");

`ifdef MUL_DISPATCH_TIMEOUT_EN
    // Multiplier never answers the first op; the second one proceeds normally.
    mul_stall = 1'b1;
    applyStimulus(16'h0102, 16'h0304, 32'd0, 1'b1);
    applyStimulus(16'h00FF, 16'hFF00, refProduct(16'h00FF, 16'hFF00), 1'b0);
    repeat (2) @(posedge clk);
    #1;
    mul_stall = 1'b0;
    waitDrain("timeout_drain");
`endif

    // Reset in the middle of WAIT_LO with two ops still queued.
    for (int i = 0; i < 3; i++) begin
      rx = 16'($urandom);
      ry = 16'($urandom);
      applyStimulus(rx, ry, refProduct(rx, ry), 1'b0);
    end
    n = 0;
    while (!mul_busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("rst_busy_seen", 32'(mul_busy), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_level_before", 32'(level), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    checkReset("reset_mid_wait");
    exp_q.delete();
    op_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    n = 0;
    while (mul_busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
    checkOutput("rst_no_late_result", 32'(res_valid), 32'd0);
    checkOutput("rst_level_after", 32'(level), 32'd0);
    applyStimulus(16'h7FFF, 16'h7FFF, 32'h3FFF0001, 1'b0);
    waitDrain("rst_fresh_drain");

    // Randomized traffic with a randomly stalling consumer.
    ready_mode = 2;
    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      rx = 16'($urandom);
      ry = 16'($urandom);
      applyStimulus(rx, ry, refProduct(rx, ry), 1'b0);
    end
    ready_mode = 1;
    waitDrain("random_drain");
    checkOutput("final_no_pending_issue", 32'(op_q.size()), 32'd0);
    checkOutput("final_level", 32'(level), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
